// File: rtl/can_pkg.sv
// Shared CAN definitions: bus levels, default stuffing/idle lengths and the
// destuffer state encoding, reused by the frame decoder and future stuffer.
package can_pkg;

   localparam logic RECESSIVE = 1'b1;
   localparam logic DOMINANT  = 1'b0;

   localparam int DEFAULT_STUFF_LEN = 5;
   localparam int DEFAULT_IDLE_LEN  = 11;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      FRAME     = 2'd2,
      ERROR     = 2'd3
   } destuff_state_e;

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN receive front end: finds bus idle and SOF, strips stuff bits inside the
// stuffed region and flags stuff violations. All outputs are registered.
module can_bit_destuffer
   import can_pkg::*;
#(
   parameter int STUFF_LEN = DEFAULT_STUFF_LEN,
   parameter int IDLE_LEN  = DEFAULT_IDLE_LEN
) (
   input  logic samplePoint,
   input  logic reset,
   input  logic canRX,
   input  logic stuffEnable,
   input  logic frameEnd,
   output logic bitOut,
   output logic bitValid,
   output logic sofDetected,
   output logic stuffError,
   output logic busIdle
);

   localparam int RUN_CNT_W  = $clog2(STUFF_LEN + 1);
   localparam int IDLE_CNT_W = $clog2(IDLE_LEN + 1);

   localparam logic [RUN_CNT_W-1:0]  RUN_ONE   = RUN_CNT_W'(1);
   localparam logic [RUN_CNT_W-1:0]  RUN_MAX   = RUN_CNT_W'(STUFF_LEN);
   localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = IDLE_CNT_W'(1);
   localparam logic [IDLE_CNT_W-1:0] IDLE_MAX  = IDLE_CNT_W'(IDLE_LEN);
   localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_LEN - 1);

   destuff_state_e          state_q, state_d;
   logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [RUN_CNT_W-1:0]    run_cnt_q, run_cnt_d;
   logic                    last_bit_q, last_bit_d;
   logic                    bit_out_q, bit_out_d;
   logic                    bit_valid_q, bit_valid_d;
   logic                    sof_q, sof_d;
   logic                    stuff_err_q, stuff_err_d;
   logic                    bus_idle_q, bus_idle_d;

   // Next-state logic; frameEnd is applied last so it overrides any other event.
   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = idle_cnt_q;
      run_cnt_d   = run_cnt_q;
      last_bit_d  = last_bit_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      sof_d       = 1'b0;
      stuff_err_d = 1'b0;

      unique case (state_q)
         WAIT_IDLE: begin
            if (canRX == RECESSIVE) begin
               if (idle_cnt_q < IDLE_MAX) begin
                  idle_cnt_d = idle_cnt_q + IDLE_ONE;
               end
               if (idle_cnt_q >= IDLE_LAST) begin
                  state_d = IDLE;
               end
            end else begin
               idle_cnt_d = '0;
            end
         end
         IDLE: begin
            if (canRX == DOMINANT) begin
               sof_d       = 1'b1;
               bit_out_d   = DOMINANT;
               bit_valid_d = 1'b1;
               last_bit_d  = DOMINANT;
               run_cnt_d   = RUN_ONE;
               state_d     = FRAME;
            end
         end
         FRAME: begin
            if (stuffEnable && (run_cnt_q == RUN_MAX)) begin
               // A stuff bit must differ from the run; it then starts the next run.
               if (canRX != last_bit_q) begin
                  last_bit_d = canRX;
                  run_cnt_d  = RUN_ONE;
               end else begin
                  stuff_err_d = 1'b1;
                  state_d     = ERROR;
               end
            end else begin
               bit_out_d   = canRX;
               bit_valid_d = 1'b1;
               last_bit_d  = canRX;
               if (stuffEnable && (canRX == last_bit_q)) begin
                  run_cnt_d = run_cnt_q + RUN_ONE;
               end else begin
                  run_cnt_d = RUN_ONE;
               end
            end
         end
         ERROR: begin
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase

      if (frameEnd && ((state_q == FRAME) || (state_q == ERROR))) begin
         state_d     = WAIT_IDLE;
         idle_cnt_d  = '0;
         run_cnt_d   = run_cnt_q;
         last_bit_d  = last_bit_q;
         bit_out_d   = bit_out_q;
         bit_valid_d = 1'b0;
         stuff_err_d = 1'b0;
      end

      bus_idle_d = (state_d == IDLE);
   end

   always_ff @(posedge samplePoint or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_IDLE;
         idle_cnt_q  <= '0;
         run_cnt_q   <= '0;
         last_bit_q  <= RECESSIVE;
         bit_out_q   <= RECESSIVE;
         bit_valid_q <= 1'b0;
         sof_q       <= 1'b0;
         stuff_err_q <= 1'b0;
         bus_idle_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         run_cnt_q   <= run_cnt_d;
         last_bit_q  <= last_bit_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         sof_q       <= sof_d;
         stuff_err_q <= stuff_err_d;
         bus_idle_q  <= bus_idle_d;
      end
   end

   assign bitOut      = bit_out_q;
   assign bitValid    = bit_valid_q;
   assign sofDetected = sof_q;
   assign stuffError  = stuff_err_q;
   assign busIdle     = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer: idle detection, SOF, destuffing,
// stuff errors, stuffEnable falling at a stuff position and async reset.
module tb_can_bit_destuffer;

   logic samplePoint;
   logic reset;
   logic canRX;
   logic stuffEnable;
   logic frameEnd;
   logic bitOut;
   logic bitValid;
   logic sofDetected;
   logic stuffError;
   logic busIdle;

   int checkCount;
   int errorCount;

   can_bit_destuffer dut (
      .samplePoint (samplePoint),
      .reset       (reset),
      .canRX       (canRX),
      .stuffEnable (stuffEnable),
      .frameEnd    (frameEnd),
      .bitOut      (bitOut),
      .bitValid    (bitValid),
      .sofDetected (sofDetected),
      .stuffError  (stuffError),
      .busIdle     (busIdle)
   );

   // Sample clock: rising edges at 5, 15, 25, ...
   initial begin
      samplePoint = 1'b0;
      forever #5 samplePoint = ~samplePoint;
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic actual, input logic expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drive one bit, let the DUT sample it, then settle 1 time unit past the edge.
   task automatic applyStimulus(input logic rx, input logic se, input logic fe);
      canRX       = rx;
      stuffEnable = se;
      frameEnd    = fe;
      @(posedge samplePoint);
      #1;
      frameEnd    = 1'b0;
   endtask

   // Feed n recessive bits and check busIdle only rises on the final one.
   task automatic sendIdle(input string tag, input int n, input logic expectIdle);
      for (int i = 0; i < n - 1; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      checkOutput({tag, "_before_last"}, busIdle, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput({tag, "_last"}, busIdle, expectIdle);
   endtask

   task automatic sendSof(input string tag);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput({tag, "_sof"}, sofDetected, 1'b1);
      checkOutput({tag, "_sof_bit"}, bitOut, 1'b0);
      checkOutput({tag, "_sof_valid"}, bitValid, 1'b1);
      checkOutput({tag, "_sof_idle"}, busIdle, 1'b0);
   endtask

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      reset       = 1'b1;
      canRX       = 1'b1;
      stuffEnable = 1'b0;
      frameEnd    = 1'b0;

      #3;
      checkOutput("rst_bitOut", bitOut, 1'b1);
      checkOutput("rst_bitValid", bitValid, 1'b0);
      checkOutput("rst_sof", sofDetected, 1'b0);
      checkOutput("rst_err", stuffError, 1'b0);
      checkOutput("rst_idle", busIdle, 1'b0);
      #9 reset = 1'b0;

      // 10 recessive then dominant must not declare idle, and clears the count
      sendIdle("idle10", 10, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle10_dom_sof", sofDetected, 1'b0);
      checkOutput("idle10_dom_valid", bitValid, 1'b0);
      sendIdle("idle11", 11, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("idle_hold", busIdle, 1'b1);
      checkOutput("idle_hold_valid", bitValid, 1'b0);

      // SOF + four dominant, recessive stuff bit, then normal bits
      sendSof("stuff");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput("stuff_dom_valid", bitValid, 1'b1);
         checkOutput("stuff_dom_bit", bitOut, 1'b0);
         checkOutput("stuff_dom_sof", sofDetected, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("stuff_drop_valid", bitValid, 1'b0);
      checkOutput("stuff_drop_err", stuffError, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("after_stuff_valid", bitValid, 1'b1);
      checkOutput("after_stuff_bit", bitOut, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("after_stuff2_valid", bitValid, 1'b1);
      checkOutput("after_stuff2_bit", bitOut, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("fe_valid", bitValid, 1'b0);
      checkOutput("fe_idle", busIdle, 1'b0);
      sendIdle("fe_idle11", 11, 1'b1);

      // Six dominant bits: violation on the sixth
      sendSof("err");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      checkOutput("err_pre_err", stuffError, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("err_pulse", stuffError, 1'b1);
      checkOutput("err_valid", bitValid, 1'b0);
      checkOutput("err_no_sof", sofDetected, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("err_hold_valid1", bitValid, 1'b0);
      checkOutput("err_single_pulse", stuffError, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("err_hold_valid2", bitValid, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("err_fe_valid", bitValid, 1'b0);
      sendIdle("err_idle11", 11, 1'b1);

      // Five recessive with stuffing on, sixth recessive with stuffEnable low
      sendSof("sefall");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput("sefall_rec_valid", bitValid, 1'b1);
         checkOutput("sefall_rec_bit", bitOut, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("sefall_6th_valid", bitValid, 1'b1);
      checkOutput("sefall_6th_bit", bitOut, 1'b1);
      checkOutput("sefall_6th_err", stuffError, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("sefall_raw_valid", bitValid, 1'b1);
      checkOutput("sefall_raw_bit", bitOut, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      sendIdle("sefall_idle11", 11, 1'b1);

      // Asynchronous reset with runCnt = 3
      sendSof("arst");
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("arst_pre_valid", bitValid, 1'b1);
      #1 reset = 1'b1;
      #1;
      checkOutput("arst_bitOut", bitOut, 1'b1);
      checkOutput("arst_valid", bitValid, 1'b0);
      checkOutput("arst_idle", busIdle, 1'b0);
      checkOutput("arst_err", stuffError, 1'b0);
      #1 reset = 1'b0;
      sendIdle("arst_idle10", 10, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("arst_early_sof", sofDetected, 1'b0);
      checkOutput("arst_early_valid", bitValid, 1'b0);
      sendIdle("arst_idle11", 11, 1'b1);
      sendSof("arst_after");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
